// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
package imem_loader_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int WORD_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    FIN
  } state_t;

endpackage

// File: rtl/loader_word_asm.sv
// Big-endian word assembler: shifts accepted bytes in MSB-first and
// publishes the full word on the fourth byte.
module loader_word_asm
  import imem_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_full
);

  localparam int CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0]         r_cnt;
  logic [WORD_W-BYTE_W-1:0] r_shift;
  logic [WORD_W-1:0]        r_word;
  logic                     w_last;

  assign w_last      = (r_cnt == CNT_W'(WORD_BYTES - 1));
  assign o_word_full = i_accept && w_last;
  assign o_word      = r_word;

  // r_word only changes on a completed word so the write data stays stable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_word  <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_accept) begin
      r_cnt   <= r_cnt + 1'b1;
      r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], i_byte};
      if (w_last) begin
        r_word <= {r_shift, i_byte};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Host byte stream to instruction-memory writer; holds the pipeline during a load.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_len_words,
  input  logic [BYTE_W-1:0] i_byte_in,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wdata,
  output logic              o_hold_pc,
  output logic              o_hold_if,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(MAX_WORDS);

  state_t          r_state;
  state_t          w_state_next;
  logic [ADDR_W:0] r_len;
  logic [ADDR_W:0] r_word_idx;
  logic [ADDR_W:0] w_idx_inc;
  logic            r_err;
  logic            r_active;
  logic            w_len_ok;
  logic            w_start_ok;
  logic            w_start_bad;
  logic            w_recv_accept;
  logic            w_word_full;
  logic            w_last_word;

  assign w_len_ok      = (i_len_words != '0) && (i_len_words <= LEN_MAX);
  assign w_start_ok    = (r_state == IDLE) && i_start && w_len_ok;
  assign w_start_bad   = (r_state == IDLE) && i_start && !w_len_ok;
  assign w_recv_accept = (r_state == RECV) && i_byte_valid;
  assign w_idx_inc     = r_word_idx + 1'b1;
  assign w_last_word   = (w_idx_inc == r_len);

  loader_word_asm u_asm (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (w_start_ok),
    .i_accept    (w_recv_accept),
    .i_byte      (i_byte_in),
    .o_word      (o_mem_wdata),
    .o_word_full (w_word_full)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_byte_ready = 1'b0;
    o_mem_we     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = w_len_ok ? RECV : FIN;
        end
      end
      RECV: begin
        o_byte_ready = 1'b1;
        if (w_word_full) begin
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        o_mem_we = 1'b1;
        if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_next = CHECK;
`else
          w_state_next = FIN;
`endif
        end else begin
          w_state_next = RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        o_byte_ready = 1'b1;
        if (i_byte_valid) begin
          w_state_next = FIN;
        end
      end
`endif
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // A rejected length still walks through FIN for the done pulse, but never holds the pipeline.
  assign o_busy     = (r_state != IDLE);
  assign o_hold_pc  = o_busy && r_active;
  assign o_hold_if  = o_busy && r_active;
  assign o_done     = (r_state == FIN);
  assign o_err      = r_err;
  assign o_mem_addr = BASE_ADDR + (32'(r_word_idx) << 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else if (w_start_ok) begin
      r_sum <= '0;
    end else if (w_recv_accept) begin
      r_sum <= r_sum + i_byte_in;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_err      <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_len      <= i_len_words;
        r_word_idx <= '0;
        r_err      <= 1'b0;
        r_active   <= 1'b1;
      end else if (w_start_bad) begin
        r_err    <= 1'b1;
        r_active <= 1'b0;
      end
      if (r_state == WRITE) begin
        r_word_idx <= w_idx_inc;
      end
      if (r_state == FIN) begin
        r_active <= 1'b0;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if ((r_state == CHECK) && i_byte_valid && (i_byte_in != r_sum)) begin
        r_err <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued from a word-level
// model of the byte stream and popped by a monitor on every mem_we.
module tb_imem_loader;

  localparam int          ADDR_W = 8;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          MAXW   = 256;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [ADDR_W:0] len_words = '0;
  logic [7:0]      byte_in = '0;
  logic            byte_valid = 1'b0;
  logic            byte_ready, mem_we, hold_pc, hold_if, busy, done, err;
  logic [31:0]     mem_addr, mem_wdata;

  int         total = 0;
  int         bad = 0;
  wr_t        sb[$];
  logic [7:0] stim[$];

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_len_words  (len_words),
    .i_byte_in    (byte_in),
    .i_byte_valid (byte_valid),
    .o_byte_ready (byte_ready),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_hold_pc    (hold_pc),
    .o_hold_if    (hold_if),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic void fail_evt(input string name);
    total++;
    bad++;
    $display("FAIL %s: got no event want event", name);
  endfunction

  // Monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin : mon
      wr_t e;
      $display("write addr=%h data=%h", mem_addr, mem_wdata);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %h want no write", mem_addr);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", mem_wdata, e.data);
      end
      chk("ready_in_write", 32'(byte_ready), 32'd0);
    end
  end

  task automatic rand_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
  endtask

  // Drives bytes from f until n are accepted; entered and left at posedge+1.
  task automatic feed_bytes(input logic [7:0] f[$], input int n, input int mode,
                            input bit poke, output int accepted);
    int cyc;
    bit acc;
    accepted = 0;
    cyc = 0;
    if (poke) len_words = (ADDR_W+1)'(1);
    while (accepted < n && cyc < 20000) begin
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = cyc[0];
        default: byte_valid = 1'($urandom_range(0, 1));
      endcase
      byte_in = byte_valid ? f[accepted] : 8'($urandom);
      start   = poke && (cyc == 2);
      @(negedge clk);
      acc = byte_valid && byte_ready;
      @(posedge clk);
      #1;
      if (acc) accepted++;
      cyc++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    if (accepted < n) fail_evt("feed_timeout");
  endtask

  task automatic run_load(input int len, input int mode, input bit ck_bad, input bit poke);
    bit         good;
    bit         exp_err;
    bit         seen;
    logic [7:0] feed[$];
    logic [7:0] sum;
    int         got;
    good    = (len >= 1) && (len <= MAXW);
    exp_err = !good;
    sum     = 8'd0;
    $display("load len=%0d mode=%0d ckbad=%0d poke=%0d", len, mode, ck_bad, poke);
    if (good) begin
      for (int i = 0; i < len; i++) begin
        wr_t w;
        w.addr = BASE + 32'(4 * i);
        w.data = {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
        sb.push_back(w);
      end
      for (int i = 0; i < 4 * len; i++) begin
        feed.push_back(stim[i]);
        sum += stim[i];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      feed.push_back(ck_bad ? sum + 8'd1 : sum);
      exp_err = ck_bad;
`endif
    end
    @(posedge clk);
    #1;
    start     = 1'b1;
    len_words = (ADDR_W+1)'(len);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    if (!good) begin
      chk("bad_done", 32'(done), 32'd1);
      chk("bad_err", 32'(err), 32'd1);
      chk("bad_hold_pc", 32'(hold_pc), 32'd0);
      chk("bad_hold_if", 32'(hold_if), 32'd0);
      @(negedge clk);
      chk("bad_done_clr", 32'(done), 32'd0);
      chk("bad_err_sticky", 32'(err), 32'd1);
      return;
    end
    chk("hold_pc_on", 32'(hold_pc), 32'd1);
    chk("hold_if_on", 32'(hold_if), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    feed_bytes(feed, feed.size(), mode, poke, got);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      fail_evt("done_timeout");
    end else begin
      chk("hold_at_done", 32'(hold_pc && hold_if), 32'd1);
      chk("err_at_done", 32'(err), 32'(exp_err));
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("hold_released", 32'(hold_pc || hold_if || busy), 32'd0);
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] tp[$];
    int         got;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 32'({byte_ready, mem_we, hold_pc, hold_if, busy, done, err}), 32'd0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    tp = '{8'h3C, 8'h08, 8'h00, 8'h01, 8'h35, 8'h08, 8'h00, 8'h02};
    stim = tp;
    run_load(2, 0, 1'b0, 1'b0);
    run_load(2, 1, 1'b0, 1'b0);

    run_load(0, 0, 1'b0, 1'b0);
    run_load(MAXW + 1, 0, 1'b0, 1'b0);

    // Reset after six accepted bytes: one word written, the second abandoned.
    rand_stim(8);
    for (int i = 0; i < 2; i++) begin
      wr_t w;
      w.addr = BASE + 32'(4 * i);
      w.data = {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
      sb.push_back(w);
    end
    @(posedge clk);
    #1;
    start     = 1'b1;
    len_words = (ADDR_W+1)'(2);
    @(posedge clk);
    #1;
    start = 1'b0;
    feed_bytes(stim, 6, 0, 1'b0, got);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 32'({byte_ready, mem_we, hold_pc, hold_if, busy, done, err}), 32'd0);
    chk("midrst_addr", mem_addr, BASE);
    chk("midrst_sb_left", 32'(sb.size()), 32'd1);
    sb.delete();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rand_stim(4);
    run_load(1, 0, 1'b0, 1'b0);

    rand_stim(12);
    run_load(3, 0, 1'b0, 1'b1);

    for (int t = 0; t < 8; t++) begin
      int l;
      l = $urandom_range(1, 5);
      rand_stim(4 * l);
      run_load(l, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    end

    rand_stim(4 * MAXW);
    run_load(MAXW, 0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    tp = '{8'h00, 8'h00, 8'h00, 8'h01};
    stim = tp;
    run_load(1, 0, 1'b0, 1'b0);
    run_load(1, 0, 1'b1, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
